// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS controller: opcodes, funct codes,
// ALU control encodings, the ALU-op class and the 4-bit FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_ADD is the all-zero code so an idle state naturally requests an add
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: decoded instruction fields and status in, selects and
// write enables out. The datapath side uses the master modport, the controller the slave.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );
endinterface

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: maps the controller's ALU-op class (and funct for R-type)
// onto the 3-bit ALU control code. Unknown funct values fall back to add.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared-memory datapath with a
// memory-ready stall. Optional BNE support is compiled in with `define MC_BNE_EN.
module mc_controller
  import mips_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.slave   bus
);

  state_t     state, state_n;
  aluop_t     aluop;
  logic       pcwrite, branch, branch_ne;
  logic       irwrite_c, memwrite_c, regwrite_c, illegal_c;
  logic       iord_c, regdst_c, memtoreg_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = S_FETCH;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    iord_c     = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;

    case (state)
      S_FETCH: begin
        alusrcb_c = 2'b01;
        // IR load and PC+4 only happen in the cycle the memory actually returns data
        if (bus.mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite   = 1'b1;
          state_n   = S_DECODE;
        end else begin
          state_n   = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BEQ;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_n = S_BNE;
`endif
          default: begin
            illegal_c = 1'b1;
            state_n   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_n   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_n = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        state_n    = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQ: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_c   = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_n   = S_ADDIWB;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JUMP: begin
        pcsrc_c = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_c   = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      default: state_n = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  // Every state-changing strobe is gated by reset so nothing writes while it is held
  assign bus.pcen     = ~reset & (pcwrite | (branch & bus.zero) | (branch_ne & ~bus.zero));
  assign bus.irwrite  = ~reset & irwrite_c;
  assign bus.memwrite = ~reset & memwrite_c;
  assign bus.regwrite = ~reset & regwrite_c;
  assign bus.illegal  = ~reset & illegal_c;
  assign bus.iord     = iord_c;
  assign bus.regdst   = regdst_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.state_o  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle vector table of inputs vs expected state and
// packed control word, plus an instruction-latency sweep. Honours `define MC_BNE_EN.
module tb_mc_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mc_controller_if bus ();

  mc_controller #(.RESET_STATE(S_FETCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
  //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal}
  logic [15:0] act;
  assign act = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};

  localparam logic [15:0] C_FETCH_ST = 16'h0044;
  localparam logic [15:0] C_FETCH    = 16'h9044;
  localparam logic [15:0] C_DECODE   = 16'h00C4;
  localparam logic [15:0] C_DEC_ILL  = 16'h00C5;
  localparam logic [15:0] C_MEMADR   = 16'h0184;
  localparam logic [15:0] C_MEMRD    = 16'h4004;
  localparam logic [15:0] C_MEMWB    = 16'h0604;
  localparam logic [15:0] C_MEMWR    = 16'h6004;
  localparam logic [15:0] C_EX_ADD   = 16'h0104;
  localparam logic [15:0] C_EX_SUB   = 16'h010C;
  localparam logic [15:0] C_EX_AND   = 16'h0100;
  localparam logic [15:0] C_EX_OR    = 16'h0102;
  localparam logic [15:0] C_EX_SLT   = 16'h010E;
  localparam logic [15:0] C_ALUWB    = 16'h0A04;
  localparam logic [15:0] C_BR_TAKEN = 16'h811C;
  localparam logic [15:0] C_BR_NOT   = 16'h011C;
  localparam logic [15:0] C_ADDIEX   = 16'h0184;
  localparam logic [15:0] C_ADDIWB   = 16'h0204;
  localparam logic [15:0] C_JUMP     = 16'h8024;
  localparam logic [15:0] M_ALL      = 16'hFFFF;
  localparam logic [15:0] M_RESET    = 16'hB201;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    state_t      st;
    logic [15:0] ctl;
    logic [15:0] mask;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input string nm, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rd, input state_t s, input logic [15:0] c,
                     input logic [15:0] m);
    vec_t v;
    v.name = nm; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rd;
    v.st = s; v.ctl = c; v.mask = m;
    vq.push_back(v);
  endtask

  task automatic vn(input string nm, input logic [5:0] o, input logic [5:0] f, input logic z,
                    input logic rd, input state_t s, input logic [15:0] c);
    add(nm, 1'b0, o, f, z, rd, s, c, M_ALL);
  endtask

  task automatic rtype(input string nm, input logic [5:0] f, input logic [15:0] ex);
    vn({nm, "_fetch"},  OP_RTYPE, f, 1'b0, 1'b1, S_FETCH,   C_FETCH);
    vn({nm, "_decode"}, OP_RTYPE, f, 1'b0, 1'b1, S_DECODE,  C_DECODE);
    vn({nm, "_exec"},   OP_RTYPE, f, 1'b0, 1'b1, S_EXECUTE, ex);
    vn({nm, "_aluwb"},  OP_RTYPE, f, 1'b0, 1'b1, S_ALUWB,   C_ALUWB);
  endtask

  task automatic check_vec(input int i);
    checks++;
    if (bus.state_o !== vq[i].st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", vq[i].name, bus.state_o, vq[i].st);
    end
    checks++;
    if ((act & vq[i].mask) !== (vq[i].ctl & vq[i].mask)) begin
      errors++;
      $display("FAIL %s ctl: got %h want %h (mask %h)", vq[i].name, act & vq[i].mask,
               vq[i].ctl & vq[i].mask, vq[i].mask);
    end
    checks++;
    if ($isunknown(act)) begin
      errors++;
      $display("FAIL %s xcheck: got %b want no X/Z", vq[i].name, act);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    int         cyc;
  } lat_t;

  lat_t lat[6];

  initial begin
    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    add("reset", 1'b1, 6'h00, 6'h00, 1'b0, 1'b1, S_FETCH, 16'h0000, M_RESET);

    rtype("add", FN_ADD, C_EX_ADD);
    rtype("sub", FN_SUB, C_EX_SUB);
    rtype("and", FN_AND, C_EX_AND);
    rtype("or",  FN_OR,  C_EX_OR);
    rtype("slt", FN_SLT, C_EX_SLT);
    rtype("fnx", 6'h27,  C_EX_ADD);

    vn("lw_fetch",  OP_LW, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("lw_decode", OP_LW, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("lw_memadr", OP_LW, 6'h00, 1'b0, 1'b1, S_MEMADR, C_MEMADR);
    vn("lw_rd0",    OP_LW, 6'h00, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    vn("lw_rd1",    OP_LW, 6'h00, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    vn("lw_rd2",    OP_LW, 6'h00, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    vn("lw_rd3",    OP_LW, 6'h00, 1'b0, 1'b1, S_MEMRD,  C_MEMRD);
    vn("lw_memwb",  OP_LW, 6'h00, 1'b0, 1'b1, S_MEMWB,  C_MEMWB);

    vn("sw_fetch",  OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("sw_decode", OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("sw_memadr", OP_SW, 6'h00, 1'b0, 1'b1, S_MEMADR, C_MEMADR);
    vn("sw_wr0",    OP_SW, 6'h00, 1'b0, 1'b0, S_MEMWR,  C_MEMWR);
    vn("sw_wr1",    OP_SW, 6'h00, 1'b0, 1'b1, S_MEMWR,  C_MEMWR);

    vn("beqt_fetch",  OP_BEQ, 6'h00, 1'b1, 1'b1, S_FETCH,  C_FETCH);
    vn("beqt_decode", OP_BEQ, 6'h00, 1'b1, 1'b1, S_DECODE, C_DECODE);
    vn("beqt_beq",    OP_BEQ, 6'h00, 1'b1, 1'b1, S_BEQ,    C_BR_TAKEN);
    vn("beqn_fetch",  OP_BEQ, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("beqn_decode", OP_BEQ, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("beqn_beq",    OP_BEQ, 6'h00, 1'b0, 1'b1, S_BEQ,    C_BR_NOT);

    vn("addi_fetch",  OP_ADDI, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("addi_decode", OP_ADDI, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("addi_ex",     OP_ADDI, 6'h00, 1'b0, 1'b1, S_ADDIEX, C_ADDIEX);
    vn("addi_wb",     OP_ADDI, 6'h00, 1'b0, 1'b1, S_ADDIWB, C_ADDIWB);

    vn("j_stall0", OP_J, 6'h00, 1'b0, 1'b0, S_FETCH,  C_FETCH_ST);
    vn("j_stall1", OP_J, 6'h00, 1'b0, 1'b0, S_FETCH,  C_FETCH_ST);
    vn("j_fetch",  OP_J, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("j_decode", OP_J, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("j_jump",   OP_J, 6'h00, 1'b0, 1'b1, S_JUMP,   C_JUMP);

    vn("ill_fetch",  6'h3F, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("ill_decode", 6'h3F, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC_ILL);

`ifdef MC_BNE_EN
    vn("bnet_fetch",  OP_BNE, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("bnet_decode", OP_BNE, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("bnet_bne",    OP_BNE, 6'h00, 1'b0, 1'b1, S_BNE,    C_BR_TAKEN);
    vn("bnen_fetch",  OP_BNE, 6'h00, 1'b1, 1'b1, S_FETCH,  C_FETCH);
    vn("bnen_decode", OP_BNE, 6'h00, 1'b1, 1'b1, S_DECODE, C_DECODE);
    vn("bnen_bne",    OP_BNE, 6'h00, 1'b1, 1'b1, S_BNE,    C_BR_NOT);
`else
    vn("bne_fetch",  OP_BNE, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("bne_decode", OP_BNE, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC_ILL);
`endif

    // Abandon a store that is still waiting on memory
    vn("rsw_fetch",  OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH,  C_FETCH);
    vn("rsw_decode", OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, C_DECODE);
    vn("rsw_memadr", OP_SW, 6'h00, 1'b0, 1'b1, S_MEMADR, C_MEMADR);
    vn("rsw_wr0",    OP_SW, 6'h00, 1'b0, 1'b0, S_MEMWR,  C_MEMWR);
    add("rsw_rst0", 1'b1, OP_SW, 6'h00, 1'b0, 1'b0, S_MEMWR, 16'h0000, M_RESET);
    add("rsw_rst1", 1'b1, OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH, 16'h0000, M_RESET);
    add("rsw_rst2", 1'b1, OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH, 16'h0000, M_RESET);
    vn("rsw_after0", OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH, C_FETCH_ST);
    vn("rsw_after1", OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH, C_FETCH_ST);

    @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset         = vq[i].rst;
      bus.op        = vq[i].op;
      bus.funct     = vq[i].funct;
      bus.zero      = vq[i].zero;
      bus.mem_ready = vq[i].rdy;
      #1;
      check_vec(i);
    end

    // Latency sweep with memory always ready
    lat[0] = '{name: "lat_rtype", op: OP_RTYPE, cyc: 4};
    lat[1] = '{name: "lat_lw",    op: OP_LW,    cyc: 5};
    lat[2] = '{name: "lat_sw",    op: OP_SW,    cyc: 4};
    lat[3] = '{name: "lat_beq",   op: OP_BEQ,   cyc: 3};
    lat[4] = '{name: "lat_addi",  op: OP_ADDI,  cyc: 4};
    lat[5] = '{name: "lat_j",     op: OP_J,     cyc: 3};

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.funct = FN_ADD;
    #1;
    for (int k = 0; k < 6; k++) begin
      int n;
      bus.op = lat[k].op;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (bus.state_o !== S_FETCH && n < 20);
      checks++;
      if (n != lat[k].cyc) begin
        errors++;
        $display("FAIL %s: got %0d cycles want %0d", lat[k].name, n, lat[k].cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
